// File: rtl/ifetch_seq32_if.sv
// Instruction-memory fetch bus between the fetch sequencer and instruction memory.
// Latency: none (wires only); the request is held until the memory acks.
// Backpressure: the memory stalls the fetch by withholding imem_ack.
interface ifetch_seq32_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Sequencer side: issues word requests and takes returned data.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Memory side: sees requests and returns data with an ack.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_seq32.sv
// Instruction-fetch sequencer: owns the PC, fetches over req/ack, issues to decode, picks next PC.
// Latency: BOOT 1 cycle after reset, then >= 2 cycles per instruction (FETCH + ISSUE).
// Backpressure: imem_ack withheld holds FETCH; stall holds ISSUE. Optional IFETCH_MISALIGN_TRAP_EN adds JR misalign trap.
module ifetch_seq32 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    ifetch_seq32_if.master    imem,
    output logic [31:0]       instruction,
    output logic [5:0]        Opcode,
    output logic [5:0]        Function_opcode,
    output logic              inst_valid,
    output logic [31:0]       pc,
    output logic [31:0]       link_addr,
    input  logic              Jrn,
    input  logic              Jmp,
    input  logic              Jal,
    input  logic              Branch,
    input  logic              nBranch,
    input  logic              Zero,
    input  logic [31:0]       Read_data_1,
`ifdef IFETCH_MISALIGN_TRAP_EN
    output logic              misalign_err,
`endif
    input  logic              stall
);

`ifdef IFETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        err_q, err_d;
`endif

    logic        br_taken;
    logic [31:0] br_offset;
    logic [31:0] jr_target;
    logic [31:0] jmp_target;
    logic [31:0] next_pc;

    // Fall-through address doubles as the JAL link value.
    assign link_addr = pc_q + 32'd4;

    // Low two bits of the JR source are masked off; a word fetch cannot use them.
    assign jr_target  = Read_data_1 & 32'hFFFF_FFFC;
    assign jmp_target = {link_addr[31:28], instr_q[25:0], 2'b00};
    assign br_offset  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign br_taken   = (Branch & Zero) | (nBranch & ~Zero);

    // Next-PC select: JR over J/JAL over taken branch over fall-through.
    always_comb begin
        next_pc = link_addr;
        if (Jrn) begin
            next_pc = jr_target;
        end else if (Jmp || Jal) begin
            next_pc = jmp_target;
        end else if (br_taken) begin
            next_pc = link_addr + br_offset;
        end
    end

    // State, PC, instruction (and trap flag) registers with async reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
`ifdef IFETCH_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    // Sequencer next-state: flags only matter in a non-stalled ISSUE, acks only in FETCH.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
        err_d   = err_q;
`endif
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
                    if (Jrn && (Read_data_1[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
`else
                    pc_d    = next_pc;
                    state_d = FETCH;
`endif
                end
            end
`ifdef IFETCH_MISALIGN_TRAP_EN
            HALT: begin
                state_d = HALT;
            end
`endif
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Outputs decode straight from the state register so reset drops the request at once.
    assign imem.imem_req  = (state_q == FETCH);
    assign imem.imem_addr = pc_q;
    assign inst_valid     = (state_q == ISSUE);
    assign pc             = pc_q;
    assign instruction    = instr_q;
    assign Opcode          = instr_q[31:26];
    assign Function_opcode = instr_q[5:0];
`ifdef IFETCH_MISALIGN_TRAP_EN
    assign misalign_err   = err_q;
`endif

endmodule

// File: tb/tb_ifetch_seq32.sv
// Directed bench for ifetch_seq32: sequential fetch, branches, jumps, JR, handshake, stall, reset.
// Inputs driven and outputs sampled on the falling clock edge; the DUT acts on the rising edge.
// Memory side modelled by directed ack/rdata from the bench.
module tb_ifetch_seq32;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction;
    logic [5:0]  Opcode;
    logic [5:0]  Function_opcode;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        Jrn = 1'b0, Jmp = 1'b0, Jal = 1'b0, Branch = 1'b0, nBranch = 1'b0, Zero = 1'b0;
    logic [31:0] Read_data_1 = 32'h0;
    logic        stall = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    ifetch_seq32_if imem_bus ();

    ifetch_seq32 #(.RESET_PC(32'h0000_0000)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem            (imem_bus.master),
        .instruction     (instruction),
        .Opcode          (Opcode),
        .Function_opcode (Function_opcode),
        .inst_valid      (inst_valid),
        .pc              (pc),
        .link_addr       (link_addr),
        .Jrn             (Jrn),
        .Jmp             (Jmp),
        .Jal             (Jal),
        .Branch          (Branch),
        .nBranch         (nBranch),
        .Zero            (Zero),
        .Read_data_1     (Read_data_1),
`ifdef IFETCH_MISALIGN_TRAP_EN
        .misalign_err    (misalign_err),
`endif
        .stall           (stall)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] ADD_W = 32'h0022_1820;  // add $3,$1,$2
    localparam logic [31:0] BEQ_W = 32'h1022_FFFE;  // beq $1,$2,-2
    localparam logic [31:0] BNE_W = 32'h1422_FFFE;  // bne $1,$2,-2
    localparam logic [31:0] JR_W  = 32'h03E0_0008;  // jr $31
    localparam logic [31:0] JAL_W = 32'h0C00_0100;  // jal target field 0x100

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_pc   = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge in FETCH; holds ack low for wait_n cycles, then returns word.
    task automatic fetch(input logic [31:0] word, input int wait_n);
        check("fetch_req", imem_bus.imem_req, 32'd1);
        check("fetch_addr", imem_bus.imem_addr, exp_pc);
        for (int i = 0; i < wait_n; i++) begin
            @(negedge clock);
            check("wait_req", imem_bus.imem_req, 32'd1);
            check("wait_addr", imem_bus.imem_addr, exp_pc);
        end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = word;
        @(negedge clock);
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        check("issue_valid", inst_valid, 32'd1);
        check("issue_req", imem_bus.imem_req, 32'd0);
        check("issue_instr", instruction, word);
        check("issue_pc", pc, exp_pc);
    endtask

    // Called at a falling edge in ISSUE; applies flags for one cycle and checks the new PC.
    task automatic issue(input logic jrn, input logic jmp, input logic jal, input logic br,
                         input logic nbr, input logic zero, input logic [31:0] rd1,
                         input logic [31:0] nxt);
        Jrn = jrn; Jmp = jmp; Jal = jal; Branch = br; nBranch = nbr; Zero = zero;
        Read_data_1 = rd1;
        @(negedge clock);
        Jrn = 1'b0; Jmp = 1'b0; Jal = 1'b0; Branch = 1'b0; nBranch = 1'b0; Zero = 1'b0;
        Read_data_1 = 32'h0;
        exp_pc = nxt;
        check("fetch_valid", inst_valid, 32'd0);
        check("next_pc", pc, nxt);
    endtask

    initial begin
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_req", imem_bus.imem_req, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_valid", inst_valid, 32'd0);
        check("rst_link", link_addr, 32'h4);
`ifdef IFETCH_MISALIGN_TRAP_EN
        check("rst_err", misalign_err, 32'd0);
`endif
        reset = 1'b1;
        #1 check("boot_req", imem_bus.imem_req, 32'd0);
        @(negedge clock);

        // Sequential stream of ADDs.
        fetch(ADD_W, 0);
        check("opcode", Opcode, 32'h0);
        check("funct", Function_opcode, 32'h20);
        issue(0, 0, 0, 0, 0, 0, 32'h0, 32'h4);
        fetch(ADD_W, 0); issue(0, 0, 0, 0, 0, 0, 32'h0, 32'h8);
        fetch(ADD_W, 0); issue(0, 0, 0, 0, 0, 0, 32'h0, 32'hC);
        fetch(ADD_W, 0); issue(0, 0, 0, 0, 0, 0, 32'h0, 32'h10);

        // Branches at 0x10 with offset -8 from 0x14.
        fetch(BEQ_W, 0); issue(0, 0, 0, 1, 0, 1, 32'h0, 32'hC);
        fetch(ADD_W, 0); issue(0, 0, 0, 0, 0, 0, 32'h0, 32'h10);
        fetch(BEQ_W, 0); issue(0, 0, 0, 1, 0, 0, 32'h0, 32'h14);
        fetch(ADD_W, 0); issue(1, 0, 0, 0, 0, 0, 32'h10, 32'h10);
        fetch(BNE_W, 0); issue(0, 0, 0, 0, 1, 0, 32'h0, 32'hC);
        fetch(BEQ_W, 0); issue(0, 0, 0, 1, 1, 1, 32'h0, 32'h8);
        fetch(BEQ_W, 0); issue(0, 0, 0, 1, 1, 0, 32'h0, 32'h4);

        // JR beats J when both are raised.
        fetch(JR_W, 0);  issue(1, 1, 0, 0, 0, 0, 32'h200, 32'h200);
`ifndef IFETCH_MISALIGN_TRAP_EN
        fetch(ADD_W, 0); issue(1, 0, 0, 0, 0, 0, 32'h207, 32'h204);
`endif

        // JAL from 0x3000_0004.
        fetch(ADD_W, 0); issue(1, 0, 0, 0, 0, 0, 32'h3000_0004, 32'h3000_0004);
        fetch(JAL_W, 0);
        check("jal_link", link_addr, 32'h3000_0008);
        issue(0, 0, 1, 0, 0, 0, 32'h0, 32'h3000_0400);

        // Reset in FETCH with the request up.
        check("pre_rst_req", imem_bus.imem_req, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_req", imem_bus.imem_req, 32'd0);
        check("mid_rst_pc", pc, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        #1 check("mid_boot_req", imem_bus.imem_req, 32'd0);
        @(negedge clock);
        exp_pc = 32'h0;

        // Delayed ack, then stall in ISSUE with a stray ack and jump flag.
        fetch(ADD_W, 3);
        stall = 1'b1; Jmp = 1'b1;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("stall_valid", inst_valid, 32'd1);
            check("stall_pc", pc, 32'h0);
            check("stall_instr", instruction, ADD_W);
        end
        stall = 1'b0; Jmp = 1'b0; imem_bus.imem_ack = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 32'h0, 32'h4);

        // Wrap of the fall-through address.
        fetch(ADD_W, 0); issue(1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        fetch(ADD_W, 0);
        check("wrap_link", link_addr, 32'h0);
        issue(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

`ifdef IFETCH_MISALIGN_TRAP_EN
        fetch(ADD_W, 0);
        Jrn = 1'b1; Read_data_1 = 32'h0000_0202;
        @(negedge clock);
        Jrn = 1'b0; Read_data_1 = 32'h0;
        check("trap_err", misalign_err, 32'd1);
        check("trap_pc", pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("halt_req", imem_bus.imem_req, 32'd0);
            check("halt_valid", inst_valid, 32'd0);
            check("halt_err", misalign_err, 32'd1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
